// File: rtl/gpr_pkg.sv
// Shared types and helpers for the multi-port register file.
// Optional parity protection is enabled with GPR_PARITY_EN.
package gpr_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } gpr_state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

  // Index of the highest set bit in the write-port hit vector (0 if none);
  // the highest-numbered matching write port always wins.
  function automatic int fwd_select(input logic [3:0] hit);
    int sel;
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      if (hit[i]) sel = i;
    end
    return sel;
  endfunction

endpackage

// File: rtl/gpr_file_mp_if.sv
// Bus interface of the multi-port register file.
// With GPR_PARITY_EN defined the interface also carries par_err.
interface gpr_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);

  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     init_done;
`ifdef GPR_PARITY_EN
  logic                     par_err;

  modport master (output we, waddr, wdata, re, raddr,
                  input  rdata, init_done, par_err);
  modport slave  (input  we, waddr, wdata, re, raddr,
                  output rdata, init_done, par_err);
`else
  modport master (output we, waddr, wdata, re, raddr,
                  input  rdata, init_done);
  modport slave  (input  we, waddr, wdata, re, raddr,
                  output rdata, init_done);
`endif

endinterface

// File: rtl/gpr_read_port.sv
// One read port: zero gating, same-cycle write forwarding, storage mux.
// With GPR_PARITY_EN defined it also flags a parity mismatch on stored reads.
module gpr_read_port
  import gpr_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     active,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0]        mem [2**ADDR_W],
`ifdef GPR_PARITY_EN
  input  logic                     par_mem [2**ADDR_W],
  output logic                     par_bad,
`endif
  output logic [DATA_W-1:0]        rdata
);

  logic [3:0] hit;

  // Zero gating first, then forwarding from a matching write, then storage.
  always_comb begin
    hit   = '0;
    rdata = '0;
`ifdef GPR_PARITY_EN
    par_bad = 1'b0;
`endif
    for (int k = 0; k < NUM_WR; k++) begin
      hit[k] = we[k] && (waddr[k*ADDR_W +: ADDR_W] == raddr);
    end
    if (!active || !re || ((ZERO_REG != 0) && (raddr == '0))) begin
      rdata = '0;
    end else if (|hit) begin
      rdata = wdata[fwd_select(hit)*DATA_W +: DATA_W];
    end else begin
      rdata = mem[raddr];
`ifdef GPR_PARITY_EN
      par_bad = ((^mem[raddr]) != par_mem[raddr]);
`endif
    end
  end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port general-purpose register file with forwarding and a
// post-reset clear sequencer. GPR_PARITY_EN adds per-entry even parity
// and a sticky par_err flag.
module gpr_file_mp
  import gpr_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  gpr_file_mp_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        mem [DEPTH];
  gpr_state_e               state, state_next;
  logic [ADDR_W-1:0]        cnt;
  logic                     init_done_q;
  logic                     active;
  logic [DATA_W-1:0]        rd_word [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rdata_flat;
`ifdef GPR_PARITY_EN
  logic                     par_mem [DEPTH];
  logic [NUM_RD-1:0]        par_bad;
  logic                     par_err_q;
`endif

  assign active = (state == RUN) && !rst;

  // State register; reset always restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  // Leave CLEAR once the last entry is being cleared.
  always_comb begin
    state_next = state;
    if ((state == CLEAR) && (cnt == '1)) state_next = RUN;
  end

  // Clear address counter, advancing once per CLEAR cycle.
  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (state == CLEAR) cnt <= cnt + 1'b1;
  end

  // init_done goes high together with the first RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) init_done_q <= 1'b0;
    else     init_done_q <= (state_next == RUN);
  end

  // Storage: clear one entry per cycle in CLEAR, port writes in RUN;
  // the later loop iteration (port 1) wins on an address conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
`ifdef GPR_PARITY_EN
        par_mem[cnt] <= 1'b0;
`endif
      end else begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (bus.we[k] && !((ZERO_REG != 0) && (bus.waddr[k*ADDR_W +: ADDR_W] == '0))) begin
            mem[bus.waddr[k*ADDR_W +: ADDR_W]] <= bus.wdata[k*DATA_W +: DATA_W];
`ifdef GPR_PARITY_EN
            par_mem[bus.waddr[k*ADDR_W +: ADDR_W]] <= ^bus.wdata[k*DATA_W +: DATA_W];
`endif
          end
        end
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    gpr_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .active (active),
      .re     (bus.re[j]),
      .raddr  (bus.raddr[j*ADDR_W +: ADDR_W]),
      .we     (bus.we),
      .waddr  (bus.waddr),
      .wdata  (bus.wdata),
      .mem    (mem),
`ifdef GPR_PARITY_EN
      .par_mem(par_mem),
      .par_bad(par_bad[j]),
`endif
      .rdata  (rd_word[j])
    );
  end

  // Pack the per-port read words onto the bus.
  always_comb begin
    rdata_flat = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      rdata_flat[j*DATA_W +: DATA_W] = rd_word[j];
    end
  end

  assign bus.rdata     = rdata_flat;
  assign bus.init_done = init_done_q;

`ifdef GPR_PARITY_EN
  // Sticky parity error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)           par_err_q <= 1'b0;
    else if (|par_bad) par_err_q <= 1'b1;
  end

  assign bus.par_err = par_err_q;
`endif

endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed self-checking bench for gpr_file_mp: dut0 with ZERO_REG=1,
// dut1 with ZERO_REG=0. Parity checks only with GPR_PARITY_EN.
module tb_gpr_file_mp;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   cycles;

  gpr_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus0 ();
  gpr_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus1 ();

  gpr_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  gpr_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus0.we = '0; bus0.waddr = '0; bus0.wdata = '0; bus0.re = '0; bus0.raddr = '0;
    bus1.we = '0; bus1.waddr = '0; bus1.wdata = '0; bus1.re = '0; bus1.raddr = '0;
  endtask

  // Drive one write port of dut0.
  task automatic applyStimulus(input int k, input logic [4:0] addr, input logic [31:0] data);
    bus0.we[k] = 1'b1;
    bus0.waddr[k*5 +: 5] = addr;
    bus0.wdata[k*32 +: 32] = data;
  endtask

  task automatic setRead(input int j, input logic [4:0] addr);
    bus0.re[j] = 1'b1;
    bus0.raddr[j*5 +: 5] = addr;
  endtask

  // Count cycles until init_done rises, bounded.
  task automatic waitInit(output int n);
    n = 0;
    while (!bus0.init_done && n < 100) begin
      tick();
      n++;
    end
    idle();
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    setRead(0, 5'd5);
    #1;
    checkOutput("reset_init_done", {31'b0, bus0.init_done}, 32'd0);
    checkOutput("reset_rdata", bus0.rdata[31:0], 32'h0);
    idle();

    // Release reset, hold a write to addr 3 through the whole clear.
    rst = 1'b0;
    applyStimulus(0, 5'd3, 32'h12345678);
    setRead(1, 5'd3);
    #1;
    checkOutput("clear_rdata", bus0.rdata[63:32], 32'h0);
    waitInit(cycles);
    checkOutput("clear_cycles", cycles, 32'd32);
    checkOutput("init_done_high", {31'b0, bus0.init_done}, 32'd1);

    for (int a = 0; a < 32; a++) begin
      setRead(0, a[4:0]);
      #1;
      checkOutput($sformatf("cleared_%0d", a), bus0.rdata[31:0], 32'h0);
    end
    idle();

    // Basic write then read.
    applyStimulus(0, 5'd7, 32'hDEADBEEF);
    tick();
    idle();
    setRead(0, 5'd7);
    #1;
    checkOutput("basic_read", bus0.rdata[31:0], 32'hDEADBEEF);
    bus0.re[0] = 1'b0;
    #1;
    checkOutput("re_low", bus0.rdata[31:0], 32'h0);
    idle();

    // Write conflict on addr 9: port 1 wins.
    applyStimulus(0, 5'd9, 32'h11111111);
    applyStimulus(1, 5'd9, 32'h22222222);
    setRead(1, 5'd9);
    #1;
    checkOutput("conflict_fwd", bus0.rdata[63:32], 32'h22222222);
    tick();
    bus0.we = '0;
    #1;
    checkOutput("conflict_stored", bus0.rdata[63:32], 32'h22222222);
    idle();

    // Forwarding over an existing value.
    applyStimulus(0, 5'd12, 32'h5);
    tick();
    idle();
    setRead(1, 5'd12);
    #1;
    checkOutput("fwd_before", bus0.rdata[63:32], 32'h5);
    applyStimulus(0, 5'd12, 32'hA5A5A5A5);
    setRead(0, 5'd12);
    #1;
    checkOutput("fwd_port1", bus0.rdata[63:32], 32'hA5A5A5A5);
    checkOutput("fwd_port0", bus0.rdata[31:0], 32'hA5A5A5A5);
    tick();
    bus0.we = '0;
    #1;
    checkOutput("fwd_stored", bus0.rdata[63:32], 32'hA5A5A5A5);
    idle();

    // Zero register on dut0, ordinary register on dut1.
    applyStimulus(0, 5'd0, 32'hFFFFFFFF);
    setRead(0, 5'd0);
    bus1.we[0] = 1'b1; bus1.waddr[4:0] = 5'd0; bus1.wdata[31:0] = 32'hFFFFFFFF;
    bus1.re[0] = 1'b1; bus1.raddr[4:0] = 5'd0;
    #1;
    checkOutput("zero_fwd", bus0.rdata[31:0], 32'h0);
    checkOutput("nozero_fwd", bus1.rdata[31:0], 32'hFFFFFFFF);
    tick();
    bus0.we = '0;
    bus1.we = '0;
    #1;
    checkOutput("zero_stored", bus0.rdata[31:0], 32'h0);
    checkOutput("nozero_stored", bus1.rdata[31:0], 32'hFFFFFFFF);
    idle();

`ifdef GPR_PARITY_EN
    // Corrupt the stored parity of addr 4 and read it.
    applyStimulus(0, 5'd4, 32'h1);
    tick();
    idle();
    dut0.par_mem[4] = ~dut0.par_mem[4];
    setRead(0, 5'd4);
    #1;
    checkOutput("par_err_before", {31'b0, bus0.par_err}, 32'd0);
    checkOutput("par_rdata", bus0.rdata[31:0], 32'h1);
    tick();
    idle();
    checkOutput("par_err_set", {31'b0, bus0.par_err}, 32'd1);
    tick();
    checkOutput("par_err_sticky", {31'b0, bus0.par_err}, 32'd1);
`endif

    // Reset in the middle of the clear sequence.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    checkOutput("midclear_init_done", {31'b0, bus0.init_done}, 32'd0);
    rst = 1'b1;
    tick();
`ifdef GPR_PARITY_EN
    checkOutput("par_err_cleared", {31'b0, bus0.par_err}, 32'd0);
`endif
    rst = 1'b0;
    waitInit(cycles);
    checkOutput("restart_cycles", cycles, 32'd32);
    setRead(0, 5'd7);
    #1;
    checkOutput("restart_cleared", bus0.rdata[31:0], 32'h0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gpr_file_mp.md
Name: gpr_file_mp

Overview:
- Parametrised multi-port general-purpose register file for the pipeline's decode/writeback stages. It replaces the single-write, dual-read register file.
- Configurable data width, depth, read-port count and write-port count.
- Same-cycle write-to-read forwarding, with deterministic write-port priority.
- After reset, a hardware clear sequencer zeroes every entry, one per cycle, and reports completion on init_done.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 2, number of write ports (1..2).
- ZERO_REG, 1, when 1 address 0 is hardwired to zero.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  NUM_WR  per-port write enable.
- waddr  in  NUM_WR*ADDR_W  packed write addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- wdata  in  NUM_WR*DATA_W  packed write data.
- re  in  NUM_RD  per-port read enable.
- raddr  in  NUM_RD*ADDR_W  packed read addresses.
- rdata  out  NUM_RD*DATA_W  packed read data; combinational.
- init_done  out  1  high once the clear sequence has finished.
- par_err  out  1  sticky parity-error flag; present only with GPR_PARITY_EN.

Behaviour:
- Reset: rst is synchronous, active-high, on clk.
  - While rst is high: FSM forced to CLEAR, clear counter set to 0, init_done=0, par_err=0.
  - rdata is 0 on all ports while rst is high or FSM is in CLEAR.
- FSM has two states, CLEAR and RUN.
  - CLEAR: each cycle, entry[cnt] <= 0 and cnt increments.
  - When cnt == 2**ADDR_W-1, the entry is written and the next state is RUN.
  - Clearing takes exactly 2**ADDR_W cycles after rst deasserts. init_done rises on the first RUN cycle and stays registered high.
  - RUN persists until rst.
- rst reasserted mid-CLEAR: counter returns to 0 and the full sequence restarts; no partial completion.
- Writes are ignored in CLEAR (we has no effect).
- In RUN, entry[waddr_k] <= wdata_k at the clock edge when we_k=1, unless ZERO_REG=1 and waddr_k=0.
- Write conflict (NUM_WR=2, both we set, equal address): port 1 wins, port 0's data is discarded.
- Reads, per port j, in priority order:
  1. rdata_j = 0 if rst, CLEAR, re_j=0, or (ZERO_REG=1 and raddr_j=0).
  2. Else, if any we_k=1 with waddr_k==raddr_j, return wdata of the highest such k (forwarding, zero latency).
  3. Else return entry[raddr_j].
- All read ports are independent; any number may read the same address.
- Write latency: the stored value is visible from the next cycle, and the same cycle via forwarding.
- With ZERO_REG=0, address 0 behaves as an ordinary register.

Optional Feature:
- Macro: GPR_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit (XOR of data), computed on write; CLEAR writes parity 0.
  - On each RUN read with re_j=1 that is not forwarded and not a zero-register access, stored parity is recomputed and compared.
  - A mismatch sets par_err at the next edge; it stays set until rst.
  - rdata is unaffected.
- Undefined: no parity storage, no par_err port; behaviour otherwise identical.

Decomposition:
- Shared package gpr_pkg holds:
  - FSM state enum (CLEAR, RUN).
  - Default width/depth constants: DATA_W=32, ADDR_W=5.
  - Zero-word constant.
  - Helper function for the highest-index address-match priority select.
- One natural sub-module: gpr_read_port (one read mux plus forwarding compare). It is instantiated NUM_RD times in a generate loop.
- Storage, write arbitration and the clear FSM stay in the top.

Test Plan:
- Reset clear: pulse rst 1 cycle, release -> init_done=0 for exactly 32 cycles, then 1. Reads of every address return 0x00000000; a write during CLEAR to addr 3 is dropped (reads 0 after RUN).
- Basic write/read: in RUN, write 0xDEADBEEF to addr 7 on port 0 -> next cycle raddr0=7, re0=1 gives 0xDEADBEEF; re0=0 gives 0.
- Write conflict: both ports write addr 9 in the same cycle, port0=0x11111111, port1=0x22222222 -> forwarded value and next-cycle stored value are both 0x22222222.
- Forwarding: addr 12 holds 0x5; same cycle we0=1, waddr0=12, wdata0=0xA5A5A5A5, raddr1=12 -> rdata1=0xA5A5A5A5 combinationally.
- Zero register: ZERO_REG=1, write 0xFFFFFFFF to addr 0 -> reads and forwarding of addr 0 return 0. With ZERO_REG=0, the read returns 0xFFFFFFFF.
- Reset mid-clear: assert rst at clear cycle 10 -> after release, init_done rises only after another full 32 cycles. With GPR_PARITY_EN, force a stored parity bit flip on addr 4 and read it -> par_err=1 next cycle, cleared only by rst.
